// File: rtl/csa_pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-select adder.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;

  function automatic int nstage(input int width, input int block);
    return width / block;
  endfunction

  function automatic bit cfg_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// Operand/result handshake bundle between operand sources, the adder and the result bus.
interface csa_pipe_adder_if #(parameter int WIDTH = adder_pkg::DEF_WIDTH);
  import adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/csa_pipe_adder_slice.sv
// One carry-select slice: both carry-in outcomes rippled in parallel, picked by cin.
module csa_slice
  import adder_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [BLOCK:0]   c0, c1;
  logic [BLOCK-1:0] s0, s1;

  assign c0[0] = 1'b0;
  assign c1[0] = 1'b1;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    assign s0[i]   = a[i] ^ b[i] ^ c0[i];
    assign c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
    assign s1[i]   = a[i] ^ b[i] ^ c1[i];
    assign c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
  end

  assign sum      = cin ? s1 : s0;
  assign cout     = cin ? c1[BLOCK] : c0[BLOCK];
  assign c_msb_in = cin ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select add/sub: one BLOCK-bit slice per stage, operands skewed
// down the pipe, whole pipe advances together under valid/ready backpressure.
module csa_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic            clk,
  input  logic            rst,
  csa_pipe_adder_if.slave bus
);

  localparam int NSTAGE = nstage(WIDTH, BLOCK);

  if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
    $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic              adv;
  logic [NSTAGE-1:0] vld_pipe;

  // A full output that is not being taken freezes every stage at once.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_st
    localparam int HI = WIDTH - k*BLOCK;

    logic [HI-1:0]          a_in, b_in;
    logic                   c_in, v_in;
    logic [BLOCK-1:0]       s_sl;
    logic                   co_sl, cm_sl;
    logic [(k+1)*BLOCK-1:0] sum_d, sum_q;
    logic                   c_q;

    if (k == 0) begin : g_src
      assign a_in  = bus.in_a;
      assign b_in  = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign c_in  = bus.in_sub | bus.in_cin;
      assign v_in  = bus.in_valid;
      assign sum_d = s_sl;
    end else begin : g_src
      assign a_in  = g_st[k-1].g_skew.a_q;
      assign b_in  = g_st[k-1].g_skew.b_q;
      assign c_in  = g_st[k-1].c_q;
      assign v_in  = vld_pipe[k-1];
      assign sum_d = {s_sl, g_st[k-1].sum_q};
    end

    csa_slice #(.BLOCK(BLOCK)) u_slice (
      .a        (a_in[BLOCK-1:0]),
      .b        (b_in[BLOCK-1:0]),
      .cin      (c_in),
      .sum      (s_sl),
      .cout     (co_sl),
      .c_msb_in (cm_sl)
    );

    // Data only loads with a valid entry, so bubbles leave the last result in place.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe[k] <= 1'b0;
        sum_q       <= '0;
        c_q         <= 1'b0;
      end else if (adv) begin
        vld_pipe[k] <= v_in;
        if (v_in) begin
          sum_q <= sum_d;
          c_q   <= co_sl;
        end
      end
    end

    if (k < NSTAGE-1) begin : g_skew
      logic [HI-BLOCK-1:0] a_q, b_q;
      logic                cm_unused;

      assign cm_unused = cm_sl;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_in) begin
          a_q <= a_in[HI-1:BLOCK];
          b_q <= b_in[HI-1:BLOCK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)              ovf_q <= 1'b0;
        else if (adv && v_in) ovf_q <= cm_sl ^ co_sl;
      end

      assign bus.out_valid = vld_pipe[k];
      assign bus.out_sum   = sum_q;
      assign bus.out_cout  = c_q;
      assign bus.out_ovf   = ovf_q;
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed bench for csa_pipe_adder: latency, carries, subtract, stall, bubbles, async reset.
module tb_csa_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csa_pipe_adder_if #(.WIDTH(16)) bus ();

  csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] r;
    logic        ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    ovf = (a[15] == bb[15]) && (r[15] != a[15]);
    return {ovf, r[16], r[15:0]};
  endfunction

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_vld"}, bus.out_valid, 1);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_sum"}, bus.out_sum, es);
    chk({tag, "_cout"}, bus.out_cout, ec);
    chk({tag, "_ovf"}, bus.out_ovf, eo);
  endtask

  logic [15:0] sa [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h0000, 16'h5555};
  logic [15:0] sb [8] = '{16'h4321, 16'h0001, 16'h7FFF, 16'h0001, 16'hF0F0, 16'h1234, 16'h0001, 16'hAAAA};
  logic        sc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        ss [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [17:0] exp_q [$];
    logic        er;
    int          issued, got, cyc;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;

    #2;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_cout", bus.out_cout, 0);
    chk("rst_ovf", bus.out_ovf, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    run_one("add0", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_one("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("cin", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);
    run_one("sub0", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Stream of 8 with out_ready low in cycles 6..8.
    issued = 0; got = 0; cyc = 0;
    @(posedge clk); #1;
    while (got < 8 && cyc < 60) begin
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      if (issued < 8) begin
        bus.in_valid = 1'b1;
        bus.in_a = sa[issued]; bus.in_b = sb[issued];
        bus.in_cin = sc[issued]; bus.in_sub = ss[issued];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      er = bus.out_ready | ~bus.out_valid;
      chk("strm_rdy", bus.in_ready, er);
      if (cyc >= 6 && cyc <= 8) chk("strm_stall_vld", bus.out_valid, 1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("strm_spurious", bus.out_valid, 0);
        end else begin
          chk($sformatf("strm_res%0d", got), {bus.out_ovf, bus.out_cout, bus.out_sum}, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(sa[issued], sb[issued], sc[issued], ss[issued]));
        issued++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("strm_cnt", got, 8);

    // Bubbles: in_valid 1,0,1,0 -> out_valid 1,0,1,0 four cycles later.
    repeat (3) @(posedge clk);
    #1;
    bus.in_sub = 1'b0; bus.in_cin = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        bus.in_valid = (c % 2 == 0);
        bus.in_a = 16'h1000 + 16'(c);
        bus.in_b = 16'h0100;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("bub_vld%0d", c), bus.out_valid, (c == 4 || c == 6));
      if (c == 4) chk("bub_sum4", bus.out_sum, 16'h1100);
      if (c == 5) chk("bub_hold5", bus.out_sum, 16'h1100);
      if (c == 6) chk("bub_sum6", bus.out_sum, 16'h1102);
      @(posedge clk); #1;
    end

    // Async reset with three operations in flight.
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = (c < 3);
      bus.in_a = 16'h0010 * 16'(c + 1);
      bus.in_b = 16'(c + 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("arst_pre_vld", bus.out_valid, 1);
    chk("arst_pre_sum", bus.out_sum, 16'h0011);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", bus.out_valid, 0);
    chk("arst_sum", bus.out_sum, 0);
    chk("arst_rdy", bus.in_ready, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("arst_stale%0d", c), bus.out_valid, 0);
    end
    run_one("arst_nxt", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
